fifo_rr_mux: RTL and testbench

Round-robin arbiter that merges num_req_p upstream fifo read ports into one downstream valid/ready stream. It shares a single consumer, such as a systolic-array row input or the UART TX path, fairly among several producer fifos. The block has a one-entry registered output stage. It pops the selected fifo with a yumi pulse and holds the word until the consumer accepts it.

---
 rtl/fifo_rr_mux.sv | 82 ++++++++
 tb/tb_fifo_rr_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_rr_mux.sv
// Round-robin merge of num_req_p fifo read ports into a single valid/ready stream.
// The output stage is a single registered entry. The selected fifo is popped with a one-hot yumi pulse.
module fifo_rr_mux #(
  parameter int width_p   = 8,
  parameter int num_req_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           valid_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           yumi_o,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic [$clog2(num_req_p)-1:0]   grant_id_o
);

  localparam int id_w = $clog2(num_req_p);

  logic               out_valid_r;
  logic [width_p-1:0] out_data_r;
  logic [id_w-1:0]    out_id_r;
  logic [id_w-1:0]    last_r;

  logic [width_p-1:0]   req_data [num_req_p];
  logic [num_req_p-1:0] vshift;
  logic [id_w-1:0]      cand;
  logic                 found;
  logic                 load_en;
  logic                 grant;
  int unsigned          idx;

  for (genvar k = 0; k < num_req_p; k++) begin : g_split
    assign req_data[k] = data_i[k*width_p +: width_p];
  end

  // Scan from last_r+1 upward. The wrap is explicit, so counts that are not a power of 2 work too.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    idx    = 0;
    vshift = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = int'(last_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      vshift = valid_i >> idx;
      if (!found && vshift[0]) begin
        found = 1'b1;
        cand  = id_w'(idx);
      end
    end
  end

  assign load_en = !out_valid_r || ready_i;
  assign grant   = load_en && found && !reset_i;

  always_comb begin
    yumi_o = '0;
    if (grant) yumi_o[cand] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      last_r      <= id_w'(num_req_p - 1);
    end else if (grant) begin
      out_valid_r <= 1'b1;
      out_data_r  <= req_data[cand];
      out_id_r    <= cand;
      last_r      <= cand;
    end else if (ready_i && out_valid_r) begin
      out_valid_r <= 1'b0;
    end
  end

  assign valid_o    = out_valid_r;
  assign data_o     = out_data_r;
  assign grant_id_o = out_id_r;

endmodule

// File: tb/tb_fifo_rr_mux.sv
// Bench for fifo_rr_mux. It drives a 4-requester and a 3-requester instance from shared stimulus.
// Both instances are checked against a rotating-priority reference model.
module tb_fifo_rr_mux;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        ready_i = 1'b0;
  logic [3:0]  valid_i = '0;
  logic [31:0] data_i = '0;

  logic [3:0]  yumi4;
  logic        v4;
  logic [7:0]  d4;
  logic [1:0]  id4;
  logic [2:0]  yumi3;
  logic        v3;
  logic [7:0]  d3;
  logic [1:0]  id3;

  int total = 0;
  int bad = 0;

  int         nreq [2] = '{4, 3};
  int         m_last [2];
  bit         m_valid [2];
  logic [7:0] m_data [2];
  int         m_id [2];

  always #5 clk_i = ~clk_i;

  fifo_rr_mux #(.width_p(8), .num_req_p(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .yumi_o(yumi4), .ready_i(ready_i), .valid_o(v4), .data_o(d4), .grant_id_o(id4)
  );

  fifo_rr_mux #(.width_p(8), .num_req_p(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i[2:0]), .data_i(data_i[23:0]),
    .yumi_o(yumi3), .ready_i(ready_i), .valid_o(v3), .data_o(d3), .grant_id_o(id3)
  );

  // Priority rotates. The requester after the last winner is asked first, and the last winner is asked last.
  function automatic int pick(int n, int last, logic [3:0] v);
    for (int j = 1; j <= n; j++) begin
      if (v[(last + j) % n]) return (last + j) % n;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit rst, logic [3:0] v, bit rdy, logic [31:0] d);
    int  cs [2];
    bit  gs [2];
    @(negedge clk_i);
    reset_i = rst;
    valid_i = v;
    ready_i = rdy;
    data_i  = d;
    #1;
    for (int u = 0; u < 2; u++) begin
      logic [3:0] ey;
      logic [3:0] vm;
      ey = '0;
      vm = v & 4'((5'b1 << nreq[u]) - 1);
      cs[u] = pick(nreq[u], m_last[u], vm);
      gs[u] = !rst && (!m_valid[u] || rdy) && cs[u] >= 0;
      if (gs[u]) ey[cs[u]] = 1'b1;
      if (u == 0) check("yumi4", 32'(yumi4), 32'(ey));
      else        check("yumi3", 32'(yumi3), 32'(ey));
    end
    @(posedge clk_i);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_valid[u] = 1'b0;
        m_data[u]  = '0;
        m_id[u]    = 0;
        m_last[u]  = nreq[u] - 1;
      end else if (gs[u]) begin
        m_valid[u] = 1'b1;
        m_data[u]  = d[cs[u]*8 +: 8];
        m_id[u]    = cs[u];
        m_last[u]  = cs[u];
      end else if (rdy && m_valid[u]) begin
        m_valid[u] = 1'b0;
      end
    end
    #1;
    check("valid4", 32'(v4), 32'(m_valid[0]));
    check("data4", 32'(d4), 32'(m_data[0]));
    check("id4", 32'(id4), 32'(m_id[0]));
    check("valid3", 32'(v3), 32'(m_valid[1]));
    check("data3", 32'(d3), 32'(m_data[1]));
    check("id3", 32'(id3), 32'(m_id[1]));
  endtask

  initial begin
    // reset, then a single requester 2
    step(1, 4'b1111, 1, 32'h0);
    step(1, 4'b0000, 0, 32'h0);
    check("rst_valid4", 32'(v4), 32'd0);
    step(0, 4'b0100, 1, 32'h0033_0000);
    check("t1_data4", 32'(d4), 32'h33);
    check("t1_id4", 32'(id4), 32'd2);

    // all valid and ready: grants walk 0,1,2,3
    step(1, 4'b0000, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b1111, 1, 32'h1312_1110);
      check("t2_id4", 32'(id4), 32'(i % 4));
      check("t2_data4", 32'(d4), 32'(8'h10 + i % 4));
      check("t5_id3", 32'(id3), 32'(i % 3));
    end

    // backpressure after the first grant, then release
    step(1, 4'b0000, 0, 32'h0);
    step(0, 4'b1111, 1, 32'h1312_1110);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1111, 0, 32'h1312_1110);
      check("t3_hold4", 32'(d4), 32'h10);
    end
    step(0, 4'b1111, 1, 32'h1312_1110);
    check("t3_next4", 32'(d4), 32'h11);

    // last winner is asked last: after a grant to 1, requesters 0 and 1 both ask, and 0 wins
    step(1, 4'b0000, 0, 32'h0);
    step(0, 4'b0010, 1, 32'h0000_2200);
    step(0, 4'b0011, 1, 32'h0000_2201);
    check("t4_wrap4", 32'(id4), 32'd0);
    step(0, 4'b0011, 1, 32'h0000_2201);
    check("t4_next4", 32'(id4), 32'd1);

    // reset while a word is held and all requesters ask
    step(0, 4'b1111, 0, 32'h4433_2211);
    step(1, 4'b1111, 1, 32'h4433_2211);
    check("t6_valid4", 32'(v4), 32'd0);
    step(0, 4'b1111, 1, 32'h4433_2211);
    check("t6_id4", 32'(id4), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
